wei_sram_arb: RTL and testbench
===============================

# wei_sram_arb

Single-port weight SRAM arbiter between the weight-load write path (interface fill of weight data) and the weight read controller that serves PE instruction requests. Read requests win by default so PE weight delivery does not stall. A starvation counter forces a write slot after a bounded wait. The block registers all SRAM control, returns read data with fixed latency, and flushes in-flight reads on config start or PE pull-back.

## Interface
- DATA_WIDTH, 128, SRAM word / port width
- ADDR_WIDTH, 16, SRAM word address width
- MAX_WAIT, 8, max consecutive cycles a pending write may be denied (≥1)
- WAIT_WIDTH, 4, width of wait counter (must hold MAX_WAIT)
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- SRAM_config_start  in  1  layer reconfig; flush pipeline, clear counters
- CCUGB_pullback_wei  in  1  PE pull-back; kill in-flight read returns
- WR_val  in  1  write request valid
- WR_rdy  out  1  write accepted this cycle when WR_val=1
- WR_addr  in  ADDR_WIDTH  write address
- WR_data  in  DATA_WIDTH  write data
- RD_req  in  1  read request (from weight read controller)
- RD_addr  in  ADDR_WIDTH  read address
- RD_gnt  out  1  read issued this cycle
- RD_data_val  out  1  RD_data valid
- RD_data  out  DATA_WIDTH  read return data
- SRAM_cs  out  1  SRAM chip select, registered
- SRAM_we  out  1  SRAM write enable, registered
- SRAM_addr  out  ADDR_WIDTH  SRAM address, registered
- SRAM_wdata  out  DATA_WIDTH  SRAM write data, registered
- SRAM_rdata  in  DATA_WIDTH  SRAM read data, valid the cycle after SRAM_cs&~SRAM_we is driven
- wr_count  out  16  completed writes since last config start, wraps at 2^16
- arb_state  out  2  00 IDLE, 01 READ_PRI, 10 WRITE_FORCE, 11 FLUSH

## Operation
- block = SRAM_config_start | CCUGB_pullback_wei | (arb_state==FLUSH).
- force_wr = (wait_cnt == MAX_WAIT).
- RD_gnt = RD_req & ~force_wr & ~block.
- WR_rdy = (~RD_req | force_wr) & ~block. WR_rdy never depends on WR_val.
- Both grants are never high in the same cycle.
- wait_cnt increments when WR_val & ~WR_rdy & ~block. It clears on a write transfer, on SRAM_config_start, or when WR_val=0. It saturates at MAX_WAIT.
- States:
  - IDLE: no RD_req and no WR_val. Goes to READ_PRI when RD_req=1.
  - READ_PRI: RD_req=1 and ~force_wr. Goes to WRITE_FORCE when force_wr=1.
  - WRITE_FORCE: lasts one cycle. Returns to READ_PRI if RD_req=1, else IDLE.
  - Any state goes to FLUSH on SRAM_config_start.
  - FLUSH lasts exactly one cycle, then IDLE.
- Pull-back does not change state. It suppresses grants only in the cycle it is high.
- Stage-1 registers load on a grant:
  - SRAM_cs=1.
  - SRAM_we=1 for a write, 0 for a read.
  - SRAM_addr from the granted port.
  - SRAM_wdata=WR_data on a write; holds its previous value on a read.
- With no grant, SRAM_cs=0 and the other stage-1 registers hold.
- rd_p1 = RD_gnt, registered. rd_p2 = rd_p1, registered.
- RD_data_val = rd_p2. RD_data = SRAM_rdata (pass-through).
- SRAM_config_start or CCUGB_pullback_wei clears rd_p1 and rd_p2 at the next edge, so no RD_data_val pulse occurs for reads issued before the event.
- An SRAM write already in stage 1 still completes.
- wr_count increments on each WR_val&WR_rdy. It clears on SRAM_config_start; clear has priority over a same-cycle increment, which is impossible anyway since block=1.

## Timing
- Reset values:
  - SRAM_cs=0, SRAM_we=0, SRAM_addr=0, SRAM_wdata=0.
  - RD_data_val=0, wr_count=0, arb_state=IDLE, wait_cnt=0.
- RD_gnt and WR_rdy are combinational; low while rst_n=0.
- Grant in cycle N: SRAM pins driven in N+1. For a read, RD_data_val=1 and RD_data valid in N+2. Latency 2, throughput 1 access per cycle.
- Back-to-back reads give back-to-back RD_data_val with no bubble.
- Write visibility: a write granted in N is readable by a read granted in N+1 or later.
- Reset asserted mid-burst: all registers clear immediately (asynchronous) and no stale RD_data_val appears after release.

## Test plan
- Reset → all outputs at reset values. Release with RD_req=0, WR_val=0 → SRAM_cs stays 0, arb_state=00.
- Write burst alone: 4 writes to addr 0x0010–0x0013, data = addr → WR_rdy=1 each cycle, SRAM_we=1 one cycle later, wr_count=4. Read back 0x0010–0x0013 → RD_data_val pulses 2 cycles after each RD_gnt with matching data.
- Contention, MAX_WAIT=8: RD_req=1 continuously, WR_val=1 from cycle 0 → RD_gnt in cycles 0–7, WR_rdy=1 only in cycle 8 (arb_state=10), RD_gnt=0 in cycle 8, reads resume in cycle 9. Pattern repeats every 9 cycles.
- Pull-back: reads granted in cycles 0–3, CCUGB_pullback_wei=1 in cycle 3 → RD_data_val only in cycles 2 and 3 (for grants 0 and 1). No RD_gnt in cycle 3, no RD_data_val in cycles 4–5.
- Config start mid-operation: pending write waiting 5 cycles, SRAM_config_start=1 → next cycle arb_state=11, wait_cnt=0, wr_count=0, no grants. IDLE the cycle after that.
- Async reset asserted the cycle after a read grant → RD_data_val never rises; all outputs return to reset values immediately.

Source files
------------

// File: rtl/wei_sram_arb_if.sv
// Bus bundle between the weight SRAM arbiter and its neighbours:
// the weight-load write path, the weight read controller, the SRAM macro,
// and the config/pull-back controls.
interface wei_sram_arb_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 16
);
  logic                  SRAM_config_start;
  logic                  CCUGB_pullback_wei;
  logic                  WR_val;
  logic                  WR_rdy;
  logic [ADDR_WIDTH-1:0] WR_addr;
  logic [DATA_WIDTH-1:0] WR_data;
  logic                  RD_req;
  logic [ADDR_WIDTH-1:0] RD_addr;
  logic                  RD_gnt;
  logic                  RD_data_val;
  logic [DATA_WIDTH-1:0] RD_data;
  logic                  SRAM_cs;
  logic                  SRAM_we;
  logic [ADDR_WIDTH-1:0] SRAM_addr;
  logic [DATA_WIDTH-1:0] SRAM_wdata;
  logic [DATA_WIDTH-1:0] SRAM_rdata;
  logic [15:0]           wr_count;
  logic [1:0]            arb_state;

  // arbiter side
  modport slave (
    input  SRAM_config_start, CCUGB_pullback_wei,
    input  WR_val, WR_addr, WR_data,
    input  RD_req, RD_addr,
    input  SRAM_rdata,
    output WR_rdy, RD_gnt, RD_data_val, RD_data,
    output SRAM_cs, SRAM_we, SRAM_addr, SRAM_wdata,
    output wr_count, arb_state
  );

  // requester / SRAM side
  modport master (
    output SRAM_config_start, CCUGB_pullback_wei,
    output WR_val, WR_addr, WR_data,
    output RD_req, RD_addr,
    output SRAM_rdata,
    input  WR_rdy, RD_gnt, RD_data_val, RD_data,
    input  SRAM_cs, SRAM_we, SRAM_addr, SRAM_wdata,
    input  wr_count, arb_state
  );
endinterface

// File: rtl/wei_sram_arb.sv
// Single-port weight SRAM arbiter. Reads win by default; a pending write
// denied MAX_WAIT cycles in a row gets a forced slot. SRAM controls are
// registered, read data returns two cycles after the grant, and in-flight
// returns are dropped on config start or PE pull-back.
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | no read traffic
// READ_PRI    | reads being served, writes only when no read is pending
// WRITE_FORCE | starved write gets this cycle's slot
// FLUSH       | one cycle after config start, all grants blocked
module wei_sram_arb #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_WAIT   = 8,
  parameter int WAIT_WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  wei_sram_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE        = 2'b00,
    S_READ_PRI    = 2'b01,
    S_WRITE_FORCE = 2'b10,
    S_FLUSH       = 2'b11
  } state_t;

  localparam logic [WAIT_WIDTH-1:0] MAX_WAIT_W = WAIT_WIDTH'(MAX_WAIT);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WAIT_WIDTH-1:0] r_wait_cnt;
  logic [WAIT_WIDTH-1:0] w_wait_nxt;
  logic                  w_kill;
  logic                  w_block;
  logic                  w_force_wr;
  logic                  w_rd_gnt;
  logic                  w_wr_rdy;
  logic                  w_wr_xfer;
  logic                  r_sram_cs;
  logic                  r_sram_we;
  logic [ADDR_WIDTH-1:0] r_sram_addr;
  logic [DATA_WIDTH-1:0] r_sram_wdata;
  logic                  r_rd_p1;
  logic                  r_rd_p2;
  logic [15:0]           r_wr_count;

  assign w_kill     = bus.SRAM_config_start | bus.CCUGB_pullback_wei;
  assign w_block    = w_kill | (r_state == S_FLUSH);
  assign w_force_wr = (r_wait_cnt == MAX_WAIT_W);
  // Grants are held off during reset so nothing downstream sees a request
  // accepted while the pipeline is being cleared.
  assign w_rd_gnt   = rst_n & bus.RD_req & ~w_force_wr & ~w_block;
  assign w_wr_rdy   = rst_n & (~bus.RD_req | w_force_wr) & ~w_block;
  assign w_wr_xfer  = bus.WR_val & w_wr_rdy;

  // Starvation counter next value: counts cycles a pending write is denied.
  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (bus.SRAM_config_start || !bus.WR_val || w_wr_xfer)
      w_wait_nxt = '0;
    else if (!w_block && !w_force_wr)
      w_wait_nxt = r_wait_cnt + WAIT_WIDTH'(1);
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wait_cnt <= '0;
    else        r_wait_cnt <= w_wait_nxt;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state. WRITE_FORCE is entered on the edge where the counter
  // reaches its limit, so the state lines up with the forced write cycle.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.SRAM_config_start) begin
      w_state_nxt = S_FLUSH;
    end else begin
      case (r_state)
        S_FLUSH:       w_state_nxt = S_IDLE;
        S_WRITE_FORCE: w_state_nxt = bus.RD_req ? S_READ_PRI : S_IDLE;
        default: begin
          if (w_wait_nxt == MAX_WAIT_W) w_state_nxt = S_WRITE_FORCE;
          else if (bus.RD_req)          w_state_nxt = S_READ_PRI;
          else                          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // FSM outputs: state code and the two combinational grants.
  always_comb begin
    bus.arb_state = r_state;
    bus.RD_gnt    = w_rd_gnt;
    bus.WR_rdy    = w_wr_rdy;
  end

  // Stage-1 SRAM control registers; write data is only loaded by writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sram_cs    <= 1'b0;
      r_sram_we    <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
    end else if (w_rd_gnt) begin
      r_sram_cs    <= 1'b1;
      r_sram_we    <= 1'b0;
      r_sram_addr  <= bus.RD_addr;
    end else if (w_wr_xfer) begin
      r_sram_cs    <= 1'b1;
      r_sram_we    <= 1'b1;
      r_sram_addr  <= bus.WR_addr;
      r_sram_wdata <= bus.WR_data;
    end else begin
      r_sram_cs    <= 1'b0;
    end
  end

  // Read return pipeline; config start or pull-back drops in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_p1 <= 1'b0;
      r_rd_p2 <= 1'b0;
    end else if (w_kill) begin
      r_rd_p1 <= 1'b0;
      r_rd_p2 <= 1'b0;
    end else begin
      r_rd_p1 <= w_rd_gnt;
      r_rd_p2 <= r_rd_p1;
    end
  end

  // Completed-write counter, cleared by config start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_wr_count <= '0;
    else if (bus.SRAM_config_start) r_wr_count <= '0;
    else if (w_wr_xfer)             r_wr_count <= r_wr_count + 16'd1;
  end

  assign bus.SRAM_cs     = r_sram_cs;
  assign bus.SRAM_we     = r_sram_we;
  assign bus.SRAM_addr   = r_sram_addr;
  assign bus.SRAM_wdata  = r_sram_wdata;
  assign bus.RD_data_val = r_rd_p2;
  assign bus.RD_data     = bus.SRAM_rdata;
  assign bus.wr_count    = r_wr_count;

endmodule

// File: tb/tb_wei_sram_arb.sv
// Testbench for wei_sram_arb: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_wei_sram_arb;
  localparam int DW = 128;
  localparam int AW = 16;
  localparam int MW = 8;
  localparam int WW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  wei_sram_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  wei_sram_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(MW), .WAIT_WIDTH(WW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // SRAM macro model: one-cycle read latency, contents zeroed on first edge.
  logic [DW-1:0] sram_mem [256];
  logic          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) sram_mem[i] <= '0;
      mem_init <= 1'b1;
    end else if (bus.SRAM_cs) begin
      if (bus.SRAM_we) sram_mem[bus.SRAM_addr[7:0]] <= bus.SRAM_wdata;
      else             bus.SRAM_rdata <= sram_mem[bus.SRAM_addr[7:0]];
    end
  end

  // Expected memory contents as seen by the requesters.
  logic [DW-1:0] refmem [256];

  typedef struct packed {
    int          due;
    logic [DW-1:0] d;
  } rexp_t;

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.RD_req = 1'b0;
    bus.WR_val = 1'b0;
    bus.SRAM_config_start = 1'b0;
    bus.CCUGB_pullback_wei = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.RD_req = 1'b1;
    bus.WR_val = 1'b1;
    bus.RD_addr = 16'h1234;
    bus.WR_addr = 16'h4321;
    bus.WR_data = rnd_data();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({bus.SRAM_cs, bus.SRAM_we, bus.SRAM_addr, bus.SRAM_wdata, bus.RD_data_val,
         bus.wr_count, bus.arb_state, bus.RD_gnt, bus.WR_rdy} !== '0)
      $display("FAIL reset_vals: cs=%b we=%b addr=%h val=%b wrc=%0d st=%b rg=%b wr=%b, all required 0",
               bus.SRAM_cs, bus.SRAM_we, bus.SRAM_addr, bus.RD_data_val, bus.wr_count,
               bus.arb_state, bus.RD_gnt, bus.WR_rdy);
    else n_pass++;
    idle_inputs();
    rst_n = 1'b1;
    nxt();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++;
      if ({bus.SRAM_cs, bus.arb_state} !== 3'b000)
        $display("FAIL idle_after_reset c%0d: cs=%b st=%b required cs=0 st=00", c, bus.SRAM_cs, bus.arb_state);
      else n_pass++;
      nxt();
    end
  endtask

  task automatic test_write_burst();
    for (int i = 0; i < 4; i++) begin
      bus.WR_val  = 1'b1;
      bus.WR_addr = AW'(16'h10 + i);
      bus.WR_data = DW'(16'h10 + i);
      @(negedge clk);
      n_chk++;
      if (bus.WR_rdy !== 1'b1) $display("FAIL wb_rdy%0d: got %b required 1", i, bus.WR_rdy);
      else n_pass++;
      if (i > 0) begin
        n_chk++;
        if ({bus.SRAM_cs, bus.SRAM_we, bus.SRAM_addr, bus.SRAM_wdata} !== {2'b11, AW'(16'h10 + i - 1), DW'(16'h10 + i - 1)})
          $display("FAIL wb_pins%0d: cs=%b we=%b addr=%h wdata=%h required 1 1 %h %h", i,
                   bus.SRAM_cs, bus.SRAM_we, bus.SRAM_addr, bus.SRAM_wdata, 16'h10 + i - 1, 16'h10 + i - 1);
        else n_pass++;
      end
      refmem[8'h10 + i] = DW'(16'h10 + i);
      nxt();
    end
    bus.WR_val = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({bus.SRAM_cs, bus.SRAM_we, bus.SRAM_addr, bus.SRAM_wdata} !== {2'b11, AW'(16'h13), DW'(16'h13)})
      $display("FAIL wb_pins3: cs=%b we=%b addr=%h required 1 1 0013", bus.SRAM_cs, bus.SRAM_we, bus.SRAM_addr);
    else n_pass++;
    n_chk++;
    if (bus.wr_count !== 16'd4) $display("FAIL wb_count: got %0d required 4", bus.wr_count);
    else n_pass++;
    nxt();
    for (int c = 0; c < 6; c++) begin
      bus.RD_req  = (c < 4);
      bus.RD_addr = AW'(16'h10 + (c % 4));
      @(negedge clk);
      if (c < 4) begin
        n_chk++;
        if (bus.RD_gnt !== 1'b1) $display("FAIL rb_gnt%0d: got %b required 1", c, bus.RD_gnt);
        else n_pass++;
      end
      n_chk++;
      if (bus.RD_data_val !== (c >= 2)) $display("FAIL rb_val%0d: got %b required %b", c, bus.RD_data_val, c >= 2);
      else n_pass++;
      if (c >= 2) begin
        n_chk++;
        if (bus.RD_data !== DW'(16'h10 + c - 2))
          $display("FAIL rb_data%0d: got %h required %h", c, bus.RD_data, 16'h10 + c - 2);
        else n_pass++;
      end
      nxt();
    end
    idle_inputs();
  endtask

  task automatic test_contention();
    logic [DW-1:0] d;
    d = rnd_data();
    bus.RD_req  = 1'b1;
    bus.WR_val  = 1'b1;
    bus.WR_addr = 16'h40;
    bus.WR_data = d;
    for (int c = 0; c < 18; c++) begin
      bit exp_w;
      exp_w = ((c % 9) == 8);
      bus.RD_addr = AW'(16'h10 + (c % 4));
      @(negedge clk);
      n_chk++;
      if ({bus.RD_gnt, bus.WR_rdy} !== {!exp_w, exp_w})
        $display("FAIL cont_grants c%0d: rg=%b wr=%b required rg=%b wr=%b", c, bus.RD_gnt, bus.WR_rdy, !exp_w, exp_w);
      else n_pass++;
      if (exp_w) begin
        n_chk++;
        if (bus.arb_state !== 2'b10) $display("FAIL cont_state c%0d: got %b required 10", c, bus.arb_state);
        else n_pass++;
      end
      nxt();
    end
    refmem[8'h40] = d;
    idle_inputs();
    nxt();
    nxt();
    @(negedge clk);
    n_chk++;
    if (bus.wr_count !== 16'd6) $display("FAIL cont_count: got %0d required 6", bus.wr_count);
    else n_pass++;
    nxt();
  endtask

  task automatic test_pullback();
    for (int c = 0; c < 6; c++) begin
      bus.RD_req  = (c < 4);
      bus.RD_addr = AW'(16'h10 + (c % 4));
      bus.CCUGB_pullback_wei = (c == 3);
      @(negedge clk);
      if (c < 4) begin
        n_chk++;
        if (bus.RD_gnt !== (c < 3)) $display("FAIL pb_gnt c%0d: got %b required %b", c, bus.RD_gnt, c < 3);
        else n_pass++;
      end
      n_chk++;
      if (bus.RD_data_val !== (c == 2 || c == 3))
        $display("FAIL pb_val c%0d: got %b required %b", c, bus.RD_data_val, (c == 2 || c == 3));
      else n_pass++;
      if (c == 4) begin
        n_chk++;
        if (bus.arb_state !== 2'b01) $display("FAIL pb_state: got %b required 01", bus.arb_state);
        else n_pass++;
      end
      nxt();
    end
    idle_inputs();
  endtask

  task automatic test_config_start();
    logic [DW-1:0] d;
    d = rnd_data();
    bus.RD_req  = 1'b1;
    bus.WR_val  = 1'b1;
    bus.WR_addr = 16'h41;
    bus.WR_data = d;
    for (int c = 0; c < 17; c++) begin
      bit erg, ewr;
      erg = (c < 5) || (c >= 7 && c != 15);
      ewr = (c == 15);
      bus.SRAM_config_start = (c == 5);
      bus.RD_addr = AW'(16'h10 + (c % 4));
      @(negedge clk);
      n_chk++;
      if ({bus.RD_gnt, bus.WR_rdy} !== {erg, ewr})
        $display("FAIL cfg_grants c%0d: rg=%b wr=%b required rg=%b wr=%b", c, bus.RD_gnt, bus.WR_rdy, erg, ewr);
      else n_pass++;
      if (c == 5) begin
        n_chk++;
        if (bus.RD_data_val !== 1'b1) $display("FAIL cfg_val_before: got %b required 1", bus.RD_data_val);
        else n_pass++;
      end
      if (c == 6) begin
        n_chk++;
        if ({bus.arb_state, bus.wr_count, bus.RD_data_val} !== {2'b11, 16'd0, 1'b0})
          $display("FAIL cfg_flush: st=%b wrc=%0d val=%b required 11 0 0", bus.arb_state, bus.wr_count, bus.RD_data_val);
        else n_pass++;
      end
      if (c == 7) begin
        n_chk++;
        if (bus.arb_state !== 2'b00) $display("FAIL cfg_idle: got %b required 00", bus.arb_state);
        else n_pass++;
      end
      if (c == 15) begin
        n_chk++;
        if (bus.arb_state !== 2'b10) $display("FAIL cfg_force_state: got %b required 10", bus.arb_state);
        else n_pass++;
      end
      if (c == 16) begin
        n_chk++;
        if (bus.wr_count !== 16'd1) $display("FAIL cfg_count: got %0d required 1", bus.wr_count);
        else n_pass++;
      end
      nxt();
    end
    refmem[8'h41] = d;
    idle_inputs();
    nxt();
    nxt();
  endtask

  task automatic test_async_reset();
    bus.RD_req  = 1'b1;
    bus.RD_addr = 16'h12;
    @(negedge clk);
    n_chk++;
    if (bus.RD_gnt !== 1'b1) $display("FAIL ar_gnt: got %b required 1", bus.RD_gnt);
    else n_pass++;
    nxt();
    bus.RD_req = 1'b0;
    n_chk++;
    if (bus.SRAM_cs !== 1'b1) $display("FAIL ar_cs_before: got %b required 1", bus.SRAM_cs);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.SRAM_cs, bus.SRAM_we, bus.SRAM_addr, bus.SRAM_wdata, bus.RD_data_val,
         bus.wr_count, bus.arb_state, bus.RD_gnt, bus.WR_rdy} !== '0)
      $display("FAIL ar_immediate: cs=%b addr=%h val=%b wrc=%0d st=%b required all 0",
               bus.SRAM_cs, bus.SRAM_addr, bus.RD_data_val, bus.wr_count, bus.arb_state);
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nxt();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_chk++;
      if (bus.RD_data_val !== 1'b0) $display("FAIL ar_no_stale c%0d: got %b required 0", c, bus.RD_data_val);
      else n_pass++;
      nxt();
    end
  endtask

  task automatic test_random();
    int            w = 0;
    bit            flush_m = 1'b0;
    int            wrc = 0;
    int            prev_kind = 0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_data = '0;
    rexp_t         q[$];
    for (int c = 0; c < 400; c++) begin
      bit rd, wv, cfg, pb, blk, frc, erg, ewr, eval;
      rd  = ($urandom_range(3) != 0);
      wv  = $urandom_range(1);
      cfg = ($urandom_range(24) == 0);
      pb  = ($urandom_range(19) == 0);
      bus.RD_req  = rd;
      bus.WR_val  = wv;
      bus.SRAM_config_start  = cfg;
      bus.CCUGB_pullback_wei = pb;
      bus.RD_addr = AW'(16'h80 + $urandom_range(15));
      bus.WR_addr = AW'(16'h80 + $urandom_range(15));
      bus.WR_data = rnd_data();
      blk = cfg || pb || flush_m;
      frc = (w == MW);
      erg = rd && !frc && !blk;
      ewr = (!rd || frc) && !blk;
      eval = (q.size() > 0) && (q[0].due == c);
      @(negedge clk);
      n_chk++;
      if ({bus.RD_gnt, bus.WR_rdy} !== {erg, ewr})
        $display("FAIL rnd_grants c%0d: rg=%b wr=%b required rg=%b wr=%b", c, bus.RD_gnt, bus.WR_rdy, erg, ewr);
      else n_pass++;
      n_chk++;
      if (bus.RD_data_val !== eval) $display("FAIL rnd_val c%0d: got %b required %b", c, bus.RD_data_val, eval);
      else n_pass++;
      if (eval) begin
        n_chk++;
        if (bus.RD_data !== q[0].d) $display("FAIL rnd_data c%0d: got %h required %h", c, bus.RD_data, q[0].d);
        else n_pass++;
        void'(q.pop_front());
      end
      n_chk++;
      if (bus.wr_count !== 16'(wrc)) $display("FAIL rnd_count c%0d: got %0d required %0d", c, bus.wr_count, wrc);
      else n_pass++;
      n_chk++;
      if (bus.SRAM_cs !== (prev_kind != 0)) $display("FAIL rnd_cs c%0d: got %b required %b", c, bus.SRAM_cs, prev_kind != 0);
      else n_pass++;
      if (prev_kind != 0) begin
        n_chk++;
        if ({bus.SRAM_we, bus.SRAM_addr} !== {prev_kind == 2, prev_addr})
          $display("FAIL rnd_pins c%0d: we=%b addr=%h required %b %h", c, bus.SRAM_we, bus.SRAM_addr, prev_kind == 2, prev_addr);
        else n_pass++;
      end
      if (prev_kind == 2) begin
        n_chk++;
        if (bus.SRAM_wdata !== prev_data) $display("FAIL rnd_wdata c%0d: got %h required %h", c, bus.SRAM_wdata, prev_data);
        else n_pass++;
      end
      if (flush_m) begin
        n_chk++;
        if (bus.arb_state !== 2'b11) $display("FAIL rnd_flush c%0d: got %b required 11", c, bus.arb_state);
        else n_pass++;
      end
      if (cfg || pb) q.delete();
      prev_kind = 0;
      if (erg) begin
        q.push_back('{due: c + 2, d: refmem[bus.RD_addr[7:0]]});
        prev_kind = 1;
        prev_addr = bus.RD_addr;
      end else if (wv && ewr) begin
        refmem[bus.WR_addr[7:0]] = bus.WR_data;
        prev_kind = 2;
        prev_addr = bus.WR_addr;
        prev_data = bus.WR_data;
      end
      if (cfg) wrc = 0;
      else if (wv && ewr) wrc = (wrc + 1) % 65536;
      if (cfg || !wv || ewr) w = 0;
      else if (!blk && w < MW) w++;
      flush_m = cfg;
      nxt();
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) refmem[i] = '0;
    bus.RD_addr = '0;
    bus.WR_addr = '0;
    bus.WR_data = '0;
    idle_inputs();
    test_reset();
    test_write_burst();
    test_contention();
    test_pullback();
    test_config_start();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
